alu_op_issue: RTL and testbench



---
 rtl/alu_op_issue.sv | 180 ++++++++++++++++++
 tb/tb_alu_op_issue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// Issue/retire stage around the ALU result mux: registers one op, waits SETTLE cycles, captures the result.
// Optional macro ALU_ILLEGAL_TRAP_EN: illegal op codes retire immediately with an error flag instead of running as ADD.
module alu_op_issue #(
    parameter int N      = 32,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_zero,
    output logic         out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t         state_r;
    state_t         state_s;
    logic [3:0]     cnt_r;
    logic [N-1:0]   alu_a_r;
    logic [N-1:0]   alu_b_r;
    logic [2:0]     alu_sel_r;
    logic [N-1:0]   out_result_r;
    logic           out_zero_r;
    logic           op_legal_s;
    logic           accept_s;
    logic           capture_s;
    logic [2:0]     sel_s;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign op_legal_s = is_legal_op(in_op);
    assign accept_s   = in_valid && (state_r == IDLE);
    assign capture_s  = (state_r == EXEC) && (cnt_r == 4'd0);

    // Handshake flags decode straight from the state register, never from inputs.
    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == HOLD);
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_sel    = alu_sel_r;
    assign out_result = out_result_r;
    assign out_zero   = out_zero_r;

    // Select code handed to the mux: raw code when trapping, illegal codes fold to ADD otherwise.
    always_comb begin
        sel_s = in_op;
`ifdef ALU_ILLEGAL_TRAP_EN
        sel_s = in_op;
`else
        if (op_legal_s) begin
            sel_s = in_op;
        end else begin
            sel_s = 3'b000;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_ILLEGAL_TRAP_EN
                    if (op_legal_s) begin
                        state_s = EXEC;
                    end else begin
                        state_s = HOLD;
                    end
`else
                    state_s = EXEC;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_s = HOLD;
                end else begin
                    state_s = EXEC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/select registers and settle counter; operands only move on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r   <= {N{1'b0}};
            alu_b_r   <= {N{1'b0}};
            alu_sel_r <= 3'b000;
            cnt_r     <= 4'd0;
        end else if (accept_s) begin
            alu_a_r   <= in_a;
            alu_b_r   <= in_b;
            alu_sel_r <= sel_s;
            cnt_r     <= CNT_LOAD;
        end else if ((state_r == EXEC) && (cnt_r != 4'd0)) begin
            cnt_r     <= cnt_r - 4'd1;
        end
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    logic out_err_r;
    assign out_err = out_err_r;

    // Result capture; a trapped op retires a zero result with the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_r <= {N{1'b0}};
            out_zero_r   <= 1'b0;
            out_err_r    <= 1'b0;
        end else if (capture_s) begin
            out_result_r <= alu_result;
            out_zero_r   <= (alu_result == {N{1'b0}});
            out_err_r    <= 1'b0;
        end else if (accept_s && !op_legal_s) begin
            out_result_r <= {N{1'b0}};
            out_zero_r   <= 1'b0;
            out_err_r    <= 1'b1;
        end
    end
`else
    assign out_err = 1'b0;

    // Result capture at the end of the settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_r <= {N{1'b0}};
            out_zero_r   <= 1'b0;
        end else if (capture_s) begin
            out_result_r <= alu_result;
            out_zero_r   <= (alu_result == {N{1'b0}});
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized self-checking bench for alu_op_issue with a transaction-level reference model.
module tb_alu_op_issue;

    localparam int N      = 32;
    localparam int SETTLE = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [N-1:0]  in_a, in_b;
    logic [N-1:0]  alu_a, alu_b;
    logic [2:0]    alu_sel;
    logic [N-1:0]  alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic          out_zero;
    logic          out_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_op_issue #(.N(N), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU datapath feeding the mux return path.
    function automatic logic [N-1:0] alu_fn(input logic [2:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic legal_op(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
    endfunction

    function automatic logic [2:0] rand_legal();
        logic [2:0] tbl [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        return tbl[$urandom_range(0, 4)];
    endfunction

    // One op: issue, check latency/result, hold backpressure for 'hold' cycles, retire.
    task automatic do_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
        logic         lg;
        logic [2:0]   e_sel;
        logic [N-1:0] e_res;
        logic         e_err, e_zero;
        int           e_lat, n;
        lg = legal_op(op);
`ifdef ALU_ILLEGAL_TRAP_EN
        e_sel = op;
        e_err = !lg;
        e_lat = lg ? SETTLE : 0;
        e_res = lg ? alu_fn(op, a, b) : '0;
`else
        e_sel = lg ? op : 3'd0;
        e_err = 1'b0;
        e_lat = SETTLE;
        e_res = alu_fn(e_sel, a, b);
`endif
        e_zero = e_err ? 1'b0 : (e_res == '0);

        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_sel", alu_sel, e_sel);

        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check("latency", n, e_lat);
        check("result", out_result, e_res);
        check("zero", out_zero, e_zero);
        check("err", out_err, e_err);
        check("busy_in_ready", in_ready, 0);
        check("sel_hold", alu_sel, e_sel);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_op = 3'($urandom); in_a = $urandom;
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_result", out_result, e_res);
            check("bp_in_ready", in_ready, 0);
            check("bp_alu_a", alu_a, a);
        end
        in_valid = 1'b1; in_a = $urandom;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check("retire_valid", out_valid, 0);
        check("retire_in_ready", in_ready, 1);
        check("retire_no_accept", alu_a, a);
    endtask

    initial begin
        logic [N-1:0] qa, qb;
        logic [N-1:0] exp_q [$];
        int           acc_t [$];
        int           n;
        logic         seen;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_err", out_err, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(3'd0, 32'd5, 32'd7, 0);
        do_op(3'd1, 32'd3, 32'd3, 0);
        do_op(3'd5, 32'd2, 32'd9, 5);
        do_op(3'd6, 32'd10, 32'd20, 1);
        do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(3'd5, 32'h8000_0000, 32'd1, 0);

        for (int t = 0; t < 25; t++) begin
            qa = $urandom;
            qb = ($urandom_range(0, 3) == 0) ? qa : $urandom;
            do_op(3'($urandom_range(0, 7)), qa, qb, $urandom_range(0, 3));
        end

        // Back-to-back with the consumer always ready.
        out_ready = 1'b1; in_valid = 1'b1;
        in_op = rand_legal(); in_a = $urandom; in_b = $urandom;
        for (int c = 0; c < 80 && (acc_t.size() < 3 || exp_q.size() > 0); c++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) check("b2b_result", out_result, exp_q.pop_front());
                else check("b2b_spurious", out_valid, 0);
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(alu_fn(in_op, in_a, in_b));
                acc_t.push_back(cyc + 1);
            end else if (!in_ready) begin
                in_op = rand_legal(); in_a = $urandom; in_b = $urandom;
                if (acc_t.size() == 3) in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_accepts", acc_t.size(), 3);
        check("b2b_pending", exp_q.size(), 0);
        if (acc_t.size() == 3) begin
            check("b2b_gap1", acc_t[1] - acc_t[0], SETTLE + 2);
            check("b2b_gap2", acc_t[2] - acc_t[1], SETTLE + 2);
        end
        repeat (2) @(negedge clk);

        // Reset two cycles into execution discards the op.
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_alu_sel", alu_sel, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_out_result", out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (SETTLE + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("post_rst_no_result", seen, 0);
        check("post_rst_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
